// File: rtl/vme_reg_bank_pkg.sv
// Shared constants, types and helpers for the VME register bank.
package vme_reg_pkg;

    localparam int unsigned VME_DATA_W = 32;
    localparam int unsigned IDX_MAX_W  = 6;   // up to 64 registers

    localparam bit ACC_RW = 1'b0;
    localparam bit ACC_RO = 1'b1;

    // Write request as seen by the decode stage (bus side or pipelined).
    typedef struct packed {
        logic                  req;
        logic [IDX_MAX_W-1:0]  idx;
        logic [VME_DATA_W-1:0] data;
    } wr_pkt_t;

    // Ceiling log2; returns 0 for n <= 1.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(n)) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/vme_reg_bank_if.sv
// VME slave-core side strobe/data bundle of the register bank.
interface vme_reg_bank_if #(
    parameter int unsigned ADDR_W = 4
) ();

    logic [ADDR_W-1:2] VMEAddr;
    logic [31:0]       VMEWrData;
    logic              VMEWrMem;
    logic              VMERdMem;
    logic [31:0]       VMERdData;
    logic              VMERdDone;
    logic              VMEWrDone;
    logic              VMEErr;

    modport master (
        output VMEAddr, VMEWrData, VMEWrMem, VMERdMem,
        input  VMERdData, VMERdDone, VMEWrDone, VMEErr
    );

    modport slave (
        input  VMEAddr, VMEWrData, VMEWrMem, VMERdMem,
        output VMERdData, VMERdDone, VMEWrDone, VMEErr
    );

endinterface

// File: rtl/vme_reg_bank_cell.sv
// One register of the bank: value, write strobe and write acknowledge.
module vme_reg_cell
    import vme_reg_pkg::*;
#(
    parameter int unsigned        FIELD_W   = 32,
    parameter logic [FIELD_W-1:0] RESET_VAL = '0,
    parameter bit                 IS_RO     = ACC_RW
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wr_en_i,
    input  logic [FIELD_W-1:0] wr_data_i,
    output logic [FIELD_W-1:0] q_o,
    output logic               wr_stb_o,
    output logic               wack_o
);

    logic wack_q;

    // Every decoded write is acknowledged, whether or not it changes the register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wack_q <= 1'b0;
        end else begin
            wack_q <= wr_en_i;
        end
    end

    assign wack_o = wack_q;

    if (IS_RO == ACC_RO) begin : g_ro
        logic [FIELD_W-1:0] unused_wr_data;
        assign unused_wr_data = wr_data_i;
        assign q_o            = '0;
        assign wr_stb_o       = 1'b0;
    end else begin : g_rw
        logic [FIELD_W-1:0] val_q;
        logic               stb_q;

        // Register value and strobe change on the same edge.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                val_q <= RESET_VAL;
                stb_q <= 1'b0;
            end else begin
                stb_q <= wr_en_i;
                if (wr_en_i) begin
                    val_q <= wr_data_i;
                end
            end
        end

        assign q_o      = val_q;
        assign wr_stb_o = stb_q;
    end

endmodule

// File: rtl/vme_reg_bank.sv
// VME-side register bank: write pipeline/decode, per-register cells, read mux/pipeline, error flag.
module vme_reg_bank
    import vme_reg_pkg::*;
#(
    parameter int unsigned                  NUM_REGS  = 4,
    parameter int unsigned                  FIELD_W   = 32,
    parameter logic [NUM_REGS-1:0]          RO_MASK   = '0,
    parameter logic [NUM_REGS*FIELD_W-1:0]  RESET_VAL = '0,
    parameter bit                           WR_PIPE   = 1'b1,
    parameter bit                           RD_PIPE   = 1'b1
) (
    input  logic                         Clk,
    input  logic                         RstN,
    vme_reg_bank_if.slave                vme,
    output logic [NUM_REGS*FIELD_W-1:0]  regs_o,
    input  logic [NUM_REGS*FIELD_W-1:0]  status_i,
    output logic [NUM_REGS-1:0]          wr_stb_o
);

    wr_pkt_t               wr_bus;
    wr_pkt_t               wr_s;
    logic [NUM_REGS-1:0]   wr_en;
    logic                  wr_unmapped;
    logic                  wr_err_q;
    logic [NUM_REGS-1:0]   wack;
    logic [VME_DATA_W-1:0] rd_data_c;
    logic                  rd_err_c;
    logic [VME_DATA_W-1:0] rd_data_s;
    logic                  rd_done_s;
    logic                  rd_err_s;

    assign wr_bus = '{req:  vme.VMEWrMem,
                      idx:  IDX_MAX_W'(vme.VMEAddr),
                      data: vme.VMEWrData};

    if (WR_PIPE) begin : g_wr_pipe
        wr_pkt_t wr_q;

        // Optional input stage for writes; a reset drops the captured request.
        always_ff @(posedge Clk or negedge RstN) begin
            if (!RstN) begin
                wr_q <= '0;
            end else begin
                wr_q <= wr_bus;
            end
        end

        assign wr_s = wr_q;
    end else begin : g_wr_direct
        assign wr_s = wr_bus;
    end

    // Write decode: one-hot enable for mapped registers, flag for unmapped ones.
    always_comb begin
        wr_en       = '0;
        wr_unmapped = wr_s.req && (32'(wr_s.idx) >= NUM_REGS);
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (wr_s.req && (32'(wr_s.idx) == i)) begin
                wr_en[i] = 1'b1;
            end
        end
    end

    // Unmapped writes are acknowledged with an error alongside the normal ack timing.
    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            wr_err_q <= 1'b0;
        end else begin
            wr_err_q <= wr_unmapped;
        end
    end

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_cell
        vme_reg_cell #(
            .FIELD_W   (FIELD_W),
            .RESET_VAL (RESET_VAL[i*FIELD_W +: FIELD_W]),
            .IS_RO     (RO_MASK[i])
        ) u_cell (
            .clk       (Clk),
            .rst_n     (RstN),
            .wr_en_i   (wr_en[i]),
            .wr_data_i (wr_s.data[FIELD_W-1:0]),
            .q_o       (regs_o[i*FIELD_W +: FIELD_W]),
            .wr_stb_o  (wr_stb_o[i]),
            .wack_o    (wack[i])
        );
    end

    logic [VME_DATA_W-1:0]       unused_wr_data;
    logic [NUM_REGS*FIELD_W-1:0] unused_status;
    assign unused_wr_data = wr_s.data;
    assign unused_status  = status_i;

    // Read mux: RW value or RO status slice, zero-extended; zero when idle or unmapped.
    always_comb begin
        rd_data_c = '0;
        rd_err_c  = 1'b0;
        if (vme.VMERdMem) begin
            if (32'(vme.VMEAddr) >= NUM_REGS) begin
                rd_err_c = 1'b1;
            end else begin
                for (int unsigned i = 0; i < NUM_REGS; i++) begin
                    if (32'(vme.VMEAddr) == i) begin
                        rd_data_c[FIELD_W-1:0] = RO_MASK[i] ? status_i[i*FIELD_W +: FIELD_W]
                                                            : regs_o[i*FIELD_W +: FIELD_W];
                    end
                end
            end
        end
    end

    if (RD_PIPE) begin : g_rd_pipe
        logic [VME_DATA_W-1:0] rd_data_q;
        logic                  rd_done_q;
        logic                  rd_err_q;

        // Read response stage: samples register contents before any same-edge write commit.
        always_ff @(posedge Clk or negedge RstN) begin
            if (!RstN) begin
                rd_data_q <= '0;
                rd_done_q <= 1'b0;
                rd_err_q  <= 1'b0;
            end else begin
                rd_data_q <= rd_data_c;
                rd_done_q <= vme.VMERdMem;
                rd_err_q  <= rd_err_c;
            end
        end

        assign rd_data_s = rd_data_q;
        assign rd_done_s = rd_done_q;
        assign rd_err_s  = rd_err_q;
    end else begin : g_rd_direct
        assign rd_data_s = rd_data_c;
        assign rd_done_s = vme.VMERdMem;
        assign rd_err_s  = rd_err_c;
    end

    assign vme.VMERdData = rd_data_s;
    assign vme.VMERdDone = rd_done_s;
    assign vme.VMEWrDone = (|wack) | wr_err_q;
    assign vme.VMEErr    = (rd_done_s & rd_err_s) | wr_err_q;

endmodule

// File: tb/tb_vme_reg_bank.sv
// Self-checking bench: pipelined (A) and fully direct (B) banks driven by one stimulus stream.
module tb_vme_reg_bank;
    import vme_reg_pkg::*;

    localparam int unsigned NR = 3;
    localparam int unsigned FW = 24;
    localparam int unsigned AW = clog2(NR) + 2;
    localparam logic [NR-1:0]    ROM = 3'b100;
    localparam logic [NR*FW-1:0] RV  = {24'h777777, 24'h5A5A5A, 24'h0000A5};
    localparam int N = 300;

    logic              Clk;
    logic              RstN;
    logic [NR*FW-1:0]  status;
    logic [NR*FW-1:0]  regs_a, regs_b;
    logic [NR-1:0]     stb_a, stb_b;

    int checks   = 0;
    int failures = 0;

    // Reference-model history for the randomized run
    logic           hw  [N];
    logic           hrd [N];
    logic [1:0]     ha  [N];
    logic [FW-1:0]  hd  [N];
    logic [FW-1:0]  hrv [2][N];
    logic [FW-1:0]  mreg [2][2];

    vme_reg_bank_if #(.ADDR_W(AW)) va ();
    vme_reg_bank_if #(.ADDR_W(AW)) vb ();

    assign vb.VMEAddr   = va.VMEAddr;
    assign vb.VMEWrData = va.VMEWrData;
    assign vb.VMEWrMem  = va.VMEWrMem;
    assign vb.VMERdMem  = va.VMERdMem;

    vme_reg_bank #(
        .NUM_REGS(NR), .FIELD_W(FW), .RO_MASK(ROM), .RESET_VAL(RV),
        .WR_PIPE(1'b1), .RD_PIPE(1'b1)
    ) u_dut_a (
        .Clk(Clk), .RstN(RstN), .vme(va.slave),
        .regs_o(regs_a), .status_i(status), .wr_stb_o(stb_a)
    );

    vme_reg_bank #(
        .NUM_REGS(NR), .FIELD_W(FW), .RO_MASK(ROM), .RESET_VAL(RV),
        .WR_PIPE(1'b0), .RD_PIPE(1'b0)
    ) u_dut_b (
        .Clk(Clk), .RstN(RstN), .vme(vb.slave),
        .regs_o(regs_b), .status_i(status), .wr_stb_o(stb_b)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic cyc();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle();
        va.VMEWrMem = 1'b0;
        va.VMERdMem = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        RstN = 1'b0;
        cyc();
        cyc();
        RstN = 1'b1;
        cyc();
    endtask

    task automatic test_reset();
        idle();
        RstN = 1'b0;
        cyc();
        cyc();
        if (regs_a !== {24'h0, 24'h5A5A5A, 24'h0000A5}) begin failures++; $display("FAIL reset_regs_a: got %h expected %h", regs_a, {24'h0, 24'h5A5A5A, 24'h0000A5}); end
        checks++;
        if (regs_b !== {24'h0, 24'h5A5A5A, 24'h0000A5}) begin failures++; $display("FAIL reset_regs_b: got %h expected %h", regs_b, {24'h0, 24'h5A5A5A, 24'h0000A5}); end
        checks++;
        if ({stb_a, va.VMERdDone, va.VMEWrDone, va.VMEErr} !== 6'b0) begin failures++; $display("FAIL reset_flags_a: got %b expected 000000", {stb_a, va.VMERdDone, va.VMEWrDone, va.VMEErr}); end
        checks++;
        if (va.VMERdData !== 32'h0) begin failures++; $display("FAIL reset_rddata_a: got %h expected 0", va.VMERdData); end
        checks++;
        RstN = 1'b1;
        cyc();
        if (regs_a[FW-1:0] !== 24'h0000A5) begin failures++; $display("FAIL reset_reg0_after: got %h expected 0000a5", regs_a[FW-1:0]); end
        checks++;
        if ({stb_b, vb.VMERdDone, vb.VMEWrDone, vb.VMEErr} !== 6'b0) begin failures++; $display("FAIL reset_flags_b: got %b expected 000000", {stb_b, vb.VMERdDone, vb.VMEWrDone, vb.VMEErr}); end
        checks++;
    endtask

    task automatic test_write();
        va.VMEAddr = 2'd1; va.VMEWrData = 32'hDEADBEEF; va.VMEWrMem = 1'b1;
        cyc();
        idle();
        if ({stb_a, va.VMEWrDone} !== 4'b0000) begin failures++; $display("FAIL wr_early_a: got %b expected 0000", {stb_a, va.VMEWrDone}); end
        checks++;
        if ({stb_b, vb.VMEWrDone} !== 4'b0101) begin failures++; $display("FAIL wr_b_ack: got %b expected 0101", {stb_b, vb.VMEWrDone}); end
        checks++;
        if (regs_b[2*FW-1:FW] !== 24'hADBEEF) begin failures++; $display("FAIL wr_b_reg1: got %h expected adbeef", regs_b[2*FW-1:FW]); end
        checks++;
        cyc();
        if ({stb_a, va.VMEWrDone, va.VMEErr} !== 5'b01010) begin failures++; $display("FAIL wr_a_ack: got %b expected 01010", {stb_a, va.VMEWrDone, va.VMEErr}); end
        checks++;
        if (regs_a[2*FW-1:FW] !== 24'hADBEEF) begin failures++; $display("FAIL wr_a_reg1: got %h expected adbeef", regs_a[2*FW-1:FW]); end
        checks++;
        if ({stb_b, vb.VMEWrDone} !== 4'b0000) begin failures++; $display("FAIL wr_b_single: got %b expected 0000", {stb_b, vb.VMEWrDone}); end
        checks++;
        cyc();
        if ({stb_a, va.VMEWrDone} !== 4'b0000) begin failures++; $display("FAIL wr_a_single: got %b expected 0000", {stb_a, va.VMEWrDone}); end
        checks++;
        va.VMEAddr = 2'd1; va.VMERdMem = 1'b1;
        #1;
        if ({vb.VMERdDone, vb.VMERdData} !== {1'b1, 32'h00ADBEEF}) begin failures++; $display("FAIL rd_b_reg1: got %h expected 100adbeef", {vb.VMERdDone, vb.VMERdData}); end
        checks++;
        if (va.VMERdDone !== 1'b0) begin failures++; $display("FAIL rd_a_early: got %b expected 0", va.VMERdDone); end
        checks++;
        cyc();
        idle();
        if ({va.VMERdDone, va.VMERdData} !== {1'b1, 32'h00ADBEEF}) begin failures++; $display("FAIL rd_a_reg1: got %h expected 100adbeef", {va.VMERdDone, va.VMERdData}); end
        checks++;
        #1;
        if ({vb.VMERdDone, vb.VMERdData} !== 33'h0) begin failures++; $display("FAIL rd_b_idle: got %h expected 0", {vb.VMERdDone, vb.VMERdData}); end
        checks++;
        cyc();
        if ({va.VMERdDone, va.VMERdData} !== 33'h0) begin failures++; $display("FAIL rd_a_idle: got %h expected 0", {va.VMERdDone, va.VMERdData}); end
        checks++;
    endtask

    task automatic test_ro();
        status = {24'h001234, 24'hCCCCCC, 24'hBBBBBB};
        va.VMEAddr = 2'd2; va.VMEWrData = 32'hFFFFFFFF; va.VMEWrMem = 1'b1;
        cyc();
        idle();
        cyc();
        if ({stb_a, va.VMEWrDone, va.VMEErr} !== 5'b00010) begin failures++; $display("FAIL ro_wr_ack: got %b expected 00010", {stb_a, va.VMEWrDone, va.VMEErr}); end
        checks++;
        if (regs_a[3*FW-1:2*FW] !== 24'h0) begin failures++; $display("FAIL ro_regs_slice: got %h expected 0", regs_a[3*FW-1:2*FW]); end
        checks++;
        va.VMEAddr = 2'd2; va.VMERdMem = 1'b1;
        cyc();
        idle();
        if ({va.VMERdDone, va.VMEErr, va.VMERdData} !== {2'b10, 32'h00001234}) begin failures++; $display("FAIL ro_rd: got %h expected 200001234", {va.VMERdDone, va.VMEErr, va.VMERdData}); end
        checks++;
        cyc();
    endtask

    task automatic test_unmapped();
        va.VMEAddr = 2'd3; va.VMEWrData = 32'h12345678; va.VMEWrMem = 1'b1;
        cyc();
        idle();
        cyc();
        if ({stb_a, va.VMEWrDone, va.VMEErr} !== 5'b00011) begin failures++; $display("FAIL unm_wr_ack: got %b expected 00011", {stb_a, va.VMEWrDone, va.VMEErr}); end
        checks++;
        if (regs_a !== {24'h0, 24'hADBEEF, 24'h0000A5}) begin failures++; $display("FAIL unm_regs: got %h expected %h", regs_a, {24'h0, 24'hADBEEF, 24'h0000A5}); end
        checks++;
        cyc();
        if ({va.VMEWrDone, va.VMEErr} !== 2'b00) begin failures++; $display("FAIL unm_err_clear: got %b expected 00", {va.VMEWrDone, va.VMEErr}); end
        checks++;
        va.VMEAddr = 2'd3; va.VMERdMem = 1'b1;
        #1;
        if ({vb.VMERdDone, vb.VMEErr, vb.VMERdData} !== {2'b11, 32'h0}) begin failures++; $display("FAIL unm_rd_b: got %h expected 300000000", {vb.VMERdDone, vb.VMEErr, vb.VMERdData}); end
        checks++;
        cyc();
        idle();
        if ({va.VMERdDone, va.VMEErr, va.VMERdData} !== {2'b11, 32'h0}) begin failures++; $display("FAIL unm_rd_a: got %h expected 300000000", {va.VMERdDone, va.VMEErr, va.VMERdData}); end
        checks++;
        cyc();
    endtask

    task automatic test_rw_same_cycle();
        va.VMEAddr = 2'd0; va.VMEWrData = 32'h1; va.VMEWrMem = 1'b1;
        cyc();
        idle();
        cyc();
        cyc();
        va.VMEAddr = 2'd0; va.VMEWrData = 32'h2; va.VMEWrMem = 1'b1; va.VMERdMem = 1'b1;
        #1;
        if (vb.VMERdData !== 32'h1) begin failures++; $display("FAIL rw_same_b_old: got %h expected 1", vb.VMERdData); end
        checks++;
        cyc();
        idle();
        if ({va.VMERdDone, va.VMERdData, va.VMEWrDone} !== {1'b1, 32'h1, 1'b0}) begin failures++; $display("FAIL rw_same_a_old: got %h expected 200000002", {va.VMERdDone, va.VMERdData, va.VMEWrDone}); end
        checks++;
        #1;
        if ({stb_b, vb.VMEWrDone, regs_b[FW-1:0]} !== {3'b001, 1'b1, 24'h2}) begin failures++; $display("FAIL rw_same_b_commit: got %h expected 3000002", {stb_b, vb.VMEWrDone, regs_b[FW-1:0]}); end
        checks++;
        cyc();
        if ({stb_a, va.VMEWrDone, regs_a[FW-1:0]} !== {3'b001, 1'b1, 24'h2}) begin failures++; $display("FAIL rw_same_a_commit: got %h expected 3000002", {stb_a, va.VMEWrDone, regs_a[FW-1:0]}); end
        checks++;
        va.VMEAddr = 2'd0; va.VMERdMem = 1'b1;
        cyc();
        idle();
        if ({va.VMERdDone, va.VMERdData} !== {1'b1, 32'h2}) begin failures++; $display("FAIL rw_same_a_new: got %h expected 100000002", {va.VMERdDone, va.VMERdData}); end
        checks++;
        cyc();
    endtask

    task automatic test_back_to_back();
        int cnt_a;
        int cnt_b;
        va.VMEAddr = 2'd1; va.VMEWrData = 32'h00CAFE01; va.VMEWrMem = 1'b1;
        cyc();
        idle();
        RstN = 1'b0;
        #1;
        if ({va.VMEWrDone, regs_a[2*FW-1:FW]} !== {1'b0, 24'h5A5A5A}) begin failures++; $display("FAIL inflight_rst: got %h expected 5a5a5a", {va.VMEWrDone, regs_a[2*FW-1:FW]}); end
        checks++;
        cyc();
        RstN = 1'b1;
        cyc();
        if ({va.VMEWrDone, regs_a[2*FW-1:FW], regs_a[FW-1:0]} !== {1'b0, 24'h5A5A5A, 24'h0000A5}) begin failures++; $display("FAIL inflight_dropped: got %h expected 05a5a5a0000a5", {va.VMEWrDone, regs_a[2*FW-1:FW], regs_a[FW-1:0]}); end
        checks++;
        cnt_a = 0;
        cnt_b = 0;
        for (int c = 0; c < 10; c++) begin
            if (c < 4) begin
                va.VMEAddr = 2'(c % 2); va.VMEWrData = 32'(32'h100 + c); va.VMEWrMem = 1'b1;
            end else begin
                idle();
            end
            cyc();
            if (va.VMEWrDone) cnt_a++;
            if (vb.VMEWrDone) cnt_b++;
        end
        if (cnt_a !== 4) begin failures++; $display("FAIL b2b_done_a: got %0d expected 4", cnt_a); end
        checks++;
        if (cnt_b !== 4) begin failures++; $display("FAIL b2b_done_b: got %0d expected 4", cnt_b); end
        checks++;
        if (regs_a[2*FW-1:0] !== {24'h000103, 24'h000102}) begin failures++; $display("FAIL b2b_regs: got %h expected 000103000102", regs_a[2*FW-1:0]); end
        checks++;
    endtask

    task automatic test_random();
        logic [95:0]    rnd;
        logic [FW-1:0]  e_data;
        logic [NR-1:0]  e_stb;
        logic [NR*FW-1:0] e_regs;
        logic           e_wd, e_we, e_rd, e_re;
        logic [31:0]    o_data;
        logic [NR-1:0]  o_stb;
        logic [NR*FW-1:0] o_regs;
        logic           o_wd, o_rd, o_err;
        int             d;
        int             src;
        do_reset();
        for (int j = 0; j < 2; j++) begin
            mreg[j][0] = 24'h0000A5;
            mreg[j][1] = 24'h5A5A5A;
        end
        for (int k = 0; k < N; k++) begin
            hw[k]  = ($urandom_range(0, 1) == 1);
            hrd[k] = ($urandom_range(0, 1) == 1);
            ha[k]  = 2'($urandom_range(0, 3));
            rnd    = {$urandom(), $urandom(), $urandom()};
            hd[k]  = rnd[FW-1:0];
            va.VMEAddr   = ha[k];
            va.VMEWrData = rnd[31:0];
            va.VMEWrMem  = hw[k];
            va.VMERdMem  = hrd[k];
            rnd    = {$urandom(), $urandom(), $urandom()};
            status = rnd[NR*FW-1:0];
            #1;
            for (int j = 0; j < 2; j++) begin
                d = (j == 0) ? 1 : 0;
                e_wd = 1'b0; e_we = 1'b0; e_stb = '0;
                src = k - 1 - d;
                if (src >= 0 && hw[src]) begin
                    e_wd = 1'b1;
                    if (ha[src] == 2'd3) e_we = 1'b1;
                    else if (ha[src] != 2'd2) begin
                        mreg[j][ha[src][0]] = hd[src];
                        e_stb[ha[src]] = 1'b1;
                    end
                end
                if (ha[k] == 2'd3)      hrv[j][k] = '0;
                else if (ha[k] == 2'd2) hrv[j][k] = status[3*FW-1:2*FW];
                else                    hrv[j][k] = mreg[j][ha[k][0]];
                src = k - d;
                e_rd   = (src >= 0) && hrd[src];
                e_data = e_rd ? hrv[j][src] : '0;
                e_re   = e_rd && (ha[src] == 2'd3);
                e_regs = {24'h0, mreg[j][1], mreg[j][0]};
                o_rd   = (j == 0) ? va.VMERdDone : vb.VMERdDone;
                o_data = (j == 0) ? va.VMERdData : vb.VMERdData;
                o_wd   = (j == 0) ? va.VMEWrDone : vb.VMEWrDone;
                o_err  = (j == 0) ? va.VMEErr    : vb.VMEErr;
                o_stb  = (j == 0) ? stb_a : stb_b;
                o_regs = (j == 0) ? regs_a : regs_b;
                if (o_rd !== e_rd) begin failures++; $display("FAIL rand_rd_done dut%0d cyc%0d: got %b expected %b", j, k, o_rd, e_rd); end
                checks++;
                if (o_data !== {8'h0, e_data}) begin failures++; $display("FAIL rand_rd_data dut%0d cyc%0d: got %h expected %h", j, k, o_data, e_data); end
                checks++;
                if (o_wd !== e_wd) begin failures++; $display("FAIL rand_wr_done dut%0d cyc%0d: got %b expected %b", j, k, o_wd, e_wd); end
                checks++;
                if (o_err !== (e_we | e_re)) begin failures++; $display("FAIL rand_err dut%0d cyc%0d: got %b expected %b", j, k, o_err, e_we | e_re); end
                checks++;
                if (o_stb !== e_stb) begin failures++; $display("FAIL rand_stb dut%0d cyc%0d: got %b expected %b", j, k, o_stb, e_stb); end
                checks++;
                if (o_regs !== e_regs) begin failures++; $display("FAIL rand_regs dut%0d cyc%0d: got %h expected %h", j, k, o_regs, e_regs); end
                checks++;
            end
            cyc();
        end
        idle();
        cyc();
        cyc();
    endtask

    initial begin
        RstN         = 1'b0;
        status       = '0;
        va.VMEAddr   = '0;
        va.VMEWrData = '0;
        va.VMEWrMem  = 1'b0;
        va.VMERdMem  = 1'b0;
        test_reset();
        test_write();
        test_ro();
        test_unmapped();
        test_rw_same_cycle();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
